regfile_dump_reader: RTL and testbench

//   Read-side sequencer for the 8x16 general-purpose register file. On a start

---
 rtl/regfile_dump_reader.sv | 109 ++++++++++
 tb/tb_regfile_dump_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Purpose : walks register addresses 0..NREG-1 through one regfile read port.
//           Each captured value goes out as a valid/ready beat tagged with its index.
// Latency : start edge -> READ next cycle -> beat 0 valid one cycle later.
//           Each later beat is valid 2 cycles after the previous one is accepted.
// Backpressure: a beat holds out_data/out_idx stable while out_ready is low.
//               No combinational path runs from out_ready to any output.
// Ports   : clk, reset (sync, active-low), start, abort
//           rd_addr -> regfile, rd_data <- regfile (combinational)
//           out_valid/out_ready/out_data/out_idx stream, busy, done pulse
module regfile_dump_reader #(
  parameter int N    = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_PRESENT, S_DONE} state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [N-1:0]  out_data_q, out_data_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) state_d = S_READ;
      end
      S_READ: begin
        // Capture happens on this edge, so a regfile write on the same edge
        // is not seen.
        out_data_d = rd_data;
        out_idx_d  = idx_q;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over everything except reset; idx returns to 0 so rd_addr
    // reads 0 in IDLE.
    if (abort && (state_q != S_IDLE)) begin
      idx_d   = '0;
      state_d = S_IDLE;
    end
  end

  // Outputs, decoded from registered state only
  always_comb begin
    out_valid = (state_q == S_PRESENT);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  assign rd_addr  = idx_q;
  assign out_data = out_data_q;
  assign out_idx  = out_idx_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Purpose : exercises regfile_dump_reader against a small regfile model.
//           Expected beats come from a snapshot of the register contents and
//           from the cycle schedule: beat 0 is two cycles after start, and
//           each later beat is two cycles after the previous acceptance.
module tb_regfile_dump_reader;
  localparam int N    = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  logic          clk, reset, start, abort, out_ready;
  logic          out_valid, busy, done;
  logic [AW-1:0] rd_addr, out_idx;
  logic [N-1:0]  rd_data, out_data;

  // regfile with one write port; the write lands on the clock edge
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_dat;
  logic [N-1:0]  rf  [NREG];
  logic [N-1:0]  mdl [NREG];

  int total = 0;
  int bad   = 0;

  regfile_dump_reader #(.N(N), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_dat;
  assign rd_data = rf[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int k, input logic [N-1:0] v);
    wr_en   = 1'b1;
    wr_addr = AW'(k);
    wr_dat  = v;
    tick();
    wr_en   = 1'b0;
    mdl[k]  = v;
  endtask

  // One full dump from IDLE. stall_beat forces a 3-cycle stall on that beat.
  // wr_beat writes BEEF on the edge that ends that beat's READ cycle.
  // noise toggles start/out_ready where they must be ignored.
  task automatic dump(input int stall_pct, input int stall_beat, input int wr_beat, input bit noise);
    logic [N-1:0] snap [NREG];
    int nst;
    for (int k = 0; k < NREG; k++) snap[k] = mdl[k];
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      chk("rd_busy",  32'(busy), 1);
      chk("rd_valid", 32'(out_valid), 0);
      chk("rd_addr",  32'(rd_addr), i);
      chk("rd_done",  32'(done), 0);
      if (i == wr_beat) begin
        wr_en = 1'b1; wr_addr = AW'(i); wr_dat = 16'hBEEF;
      end
      if (noise) begin
        start     = 1'($urandom_range(1));
        out_ready = 1'($urandom_range(1));
      end
      tick();
      wr_en = 1'b0;
      if (i == stall_beat) nst = 3;
      else if (int'($urandom_range(99)) < stall_pct) nst = int'($urandom_range(4, 1));
      else nst = 0;
      for (int s = 0; s <= nst; s++) begin
        chk("beat_valid", 32'(out_valid), 1);
        chk("beat_idx",   32'(out_idx), i);
        chk("beat_data",  32'(out_data), 32'(snap[i]));
        chk("beat_done",  32'(done), 0);
        out_ready = (s == nst);
        if (noise) start = 1'($urandom_range(1));
        tick();
      end
      out_ready = 1'b0;
    end
    chk("done_pulse", 32'(done), 1);
    chk("done_valid", 32'(out_valid), 0);
    if (noise) start = 1'($urandom_range(1));
    tick();
    start = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    if (wr_beat >= 0) mdl[wr_beat] = 16'hBEEF;
  endtask

  // Starts a dump and accepts beats 0..k-1; it returns in the READ cycle of beat k.
  task automatic run_to(input int k);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < k; j++) begin
      tick();
      chk("pre_idx", 32'(out_idx), j);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int r;
    int expv;
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_dat = '0;
    start = 1'b1; abort = 1'b1;   // reset must override both
    repeat (3) tick();
    start = 1'b0; abort = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_idx",   32'(out_idx), 0);
    chk("rst_addr",  32'(rd_addr), 0);
    reset = 1'b1;
    tick();

    // straight dump of Rk = 1111*k
    for (int k = 0; k < NREG; k++) load(k, 16'(16'h1111 * k));
    dump(0, -1, -1, 1'b0);

    // 3-cycle stall on beat 2
    dump(0, 2, -1, 1'b0);

    // abort while beat 4 is presented
    run_to(4);
    tick();
    chk("ab_valid_pre", 32'(out_valid), 1);
    chk("ab_idx_pre",   32'(out_idx), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 32'(out_valid), 0);
    chk("ab_busy",  32'(busy), 0);
    chk("ab_done",  32'(done), 0);
    repeat (3) begin
      tick();
      chk("ab_nodone", 32'(done), 0);
    end
    dump(0, -1, -1, 1'b0);

    // reset in the READ cycle of beat 5
    run_to(5);
    chk("rs_addr_pre", 32'(rd_addr), 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rs_valid", 32'(out_valid), 0);
    chk("rs_busy",  32'(busy), 0);
    chk("rs_done",  32'(done), 0);
    chk("rs_data",  32'(out_data), 0);
    chk("rs_idx",   32'(out_idx), 0);
    chk("rs_addr",  32'(rd_addr), 0);
    tick();
    chk("rs_nodone", 32'(done), 0);
    dump(20, -1, -1, 1'b0);

    // start pulses mid-dump are ignored
    dump(0, -1, -1, 1'b1);
    dump(30, -1, -1, 1'b1);

    // start held high: two back-to-back dumps of period 2*NREG+2
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 2 * (2 * NREG + 2) - 1; c++) begin
      tick();
      r = c % (2 * NREG + 2);
      expv = (r >= 2 && r <= 2 * NREG && (r % 2) == 0) ? 1 : 0;
      chk("b2b_valid", 32'(out_valid), expv);
      chk("b2b_busy",  32'(busy), (r != 0) ? 1 : 0);
      chk("b2b_done",  32'(done), (r == 2 * NREG + 1) ? 1 : 0);
      if (expv == 1) begin
        chk("b2b_idx",  32'(out_idx), (r - 2) / 2);
        chk("b2b_data", 32'(out_data), 32'(mdl[(r - 2) / 2]));
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("b2b_idle", 32'(busy), 0);

    // write on the READ edge is not observed; the next dump sees it
    dump(0, -1, 6, 1'b0);
    dump(0, -1, -1, 1'b0);

    // randomized contents, stalls and ignored starts
    repeat (15) begin
      for (int k = 0; k < NREG; k++) load(k, 16'($urandom));
      dump(40, -1, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
